// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - op encodings carried on the 3-bit op bus (6 and 7 are reserved)
//   - default busy durations for multiply and divide
//   - FSM state type used by the top level
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core of the multiply/divide unit.
// Produces the 64-bit {hi,lo} result for the requested op:
//   MULT/MULTU : signed / unsigned 64-bit product
//   DIV/DIVU   : {remainder, quotient}; signed divide truncates toward zero
//   divide by zero gives {A, 32'hFFFF_FFFF}; whether that result is actually
//   written is decided by the top level.
// Ports:
//   i_op     in  3   operation code (mdu_op_e encoding)
//   i_a      in  32  operand rs
//   i_b      in  32  operand rt
//   o_result out 64  {hi, lo} result, zero for MTHI/MTLO/reserved ops
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result
);

  logic        w_sdiv;
  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic [31:0] w_da;
  logic [31:0] w_db;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_sdiv = (i_op == MDU_DIV);

  assign w_smul = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_umul = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide runs on magnitudes through one unsigned divider. The
  // magnitude of 0x8000_0000 is still 0x8000_0000 as an unsigned value, so
  // 0x8000_0000 / -1 naturally yields quotient 0x8000_0000, remainder 0.
  assign w_da = (w_sdiv && i_a[31]) ? (~i_a + 32'd1) : i_a;
  assign w_db = (w_sdiv && i_b[31]) ? (~i_b + 32'd1) : i_b;
  assign w_uq = (w_db == 32'd0) ? 32'd0 : (w_da / w_db);
  assign w_ur = (w_db == 32'd0) ? 32'd0 : (w_da % w_db);

  // Quotient is negative when operand signs differ; remainder follows dividend.
  assign w_q = (w_sdiv && (i_a[31] ^ i_b[31])) ? (~w_uq + 32'd1) : w_uq;
  assign w_r = (w_sdiv && i_a[31]) ? (~w_ur + 32'd1) : w_ur;

  always_comb begin
    o_result = 64'd0;
    case (i_op)
      MDU_MULT:          o_result = w_smul;
      MDU_MULTU:         o_result = w_umul;
      MDU_DIV, MDU_DIVU: o_result = (i_b == 32'd0) ? {i_a, 32'hFFFF_FFFF} : {w_r, w_q};
      default:           o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit with private HI/LO registers.
// The result is computed at the accepting edge, parked in a pending register,
// and written to HI/LO on the edge where the busy countdown reaches zero.
// MTHI/MTLO write immediately without a busy window.
//
// Build option: MDU_DIVZERO_KEEP_EN
//   defined   : divide by zero leaves HI/LO untouched after the busy window
//   undefined : divide by zero writes LO=0xFFFF_FFFF, HI=A
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous active-low reset
//   start  in   1   one-cycle request strobe
//   op     in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
//   A      in   32  forwarded rs operand
//   B      in   32  forwarded rt operand
//   busy   out  1   multiply/divide in flight (registered, from counter)
//   HI     out  32  HI register
//   LO     out  32  LO register
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | counter == 0, start accepted
// ST_RUN  | counter > 0, decrement each edge, commit pending on 1 -> 0
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_e       r_state;
  mdu_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [63:0]      r_pend;
  logic             r_pend_we;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [63:0]      w_arith;
  logic             w_pend_we;
  logic             w_load;
  logic             w_commit;
  logic             w_wr_hi;
  logic             w_wr_lo;

  mdu_arith u_arith (
    .i_op     (op),
    .i_a      (A),
    .i_b      (B),
    .o_result (w_arith)
  );

`ifdef MDU_DIVZERO_KEEP_EN
  logic w_is_div;
  assign w_is_div  = (op == MDU_DIV) || (op == MDU_DIVU);
  // A zero divisor still occupies the full divide window but never commits.
  assign w_pend_we = !(w_is_div && (B == 32'd0));
`else
  assign w_pend_we = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              w_load      = 1'b1;
              w_cnt_nxt   = MULT_LOAD;
              w_state_nxt = ST_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              w_load      = 1'b1;
              w_cnt_nxt   = DIV_LOAD;
              w_state_nxt = ST_RUN;
            end
            MDU_MTHI: w_wr_hi = 1'b1;
            MDU_MTLO: w_wr_lo = 1'b1;
            default:  ;
          endcase
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pend    <= 64'd0;
      r_pend_we <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_pend    <= w_arith;
        r_pend_we <= w_pend_we;
      end
      if (w_commit && r_pend_we) begin
        r_hi <= r_pend[63:32];
        r_lo <= r_pend[31:0];
      end
      if (w_wr_hi) r_hi <= A;
      if (w_wr_lo) r_lo <= A;
    end
  end

  assign busy = (r_cnt != '0);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
